// File: rtl/freq_stat_ctrl.sv
// Sequencer for the four-bank symbol-frequency RAM: clean, statistics gating, merged readout.
// Define FREQ_TOTAL_EN to add total_freq, the running sum of all transferred counts.
module freq_stat_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        blk_start,
    input  logic        blk_end,
    output logic        stat_ready,
    output logic        ram_clean,
    input  logic        ram_busy,
    output logic        ram_stat_en,
    output logic        freq_oe,
    output logic [7:0]  freq_addr_a,
    output logic [7:0]  freq_addr_b,
    input  logic [17:0] freq_value1a,
    input  logic [17:0] freq_value2a,
    input  logic [17:0] freq_value3a,
    input  logic [17:0] freq_value4a,
    input  logic [17:0] freq_value1b,
    input  logic [17:0] freq_value2b,
    input  logic [17:0] freq_value3b,
    input  logic [17:0] freq_value4b,
    input  logic        freq_valid,
    output logic [7:0]  sym_idx,
    output logic [19:0] sym_freq0,
    output logic [19:0] sym_freq1,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic        done,
    output logic        ctrl_busy
`ifdef FREQ_TOTAL_EN
  , output logic [27:0] total_freq
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAN, S_CLR_WAIT, S_STAT, S_DRAIN, S_READ, S_FLUSH, S_DONE
    } state_t;

    function automatic logic [19:0] merge4(input logic [17:0] a, input logic [17:0] b,
                                           input logic [17:0] c, input logic [17:0] d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    state_t      r_state;
    logic        r_clean;
    logic        r_stat_en;
    logic        r_stat_ready;
    logic        r_done;
    logic        r_busy;
    logic        r_busy_seen;
    logic        r_guard;
    logic        r_drain_cnt;
    logic [6:0]  r_rd_cnt;

    logic        r_vld_p1;
    logic [6:0]  r_idx_p1;

    logic [6:0]  r_fifo_idx [2];
    logic [19:0] r_fifo_f0  [2];
    logic [19:0] r_fifo_f1  [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_fifo_cnt;

    logic        w_pop;
    logic        w_push;
    logic [2:0]  w_occ;
    logic        w_issue;

    // Occupancy counts the FIFO after this cycle's pop plus the read whose data arrives now.
    assign w_pop   = sym_valid & sym_ready;
    assign w_push  = freq_valid & r_vld_p1;
    assign w_occ   = {1'b0, r_fifo_cnt} + {2'b00, r_vld_p1} - {2'b00, w_pop};
    assign w_issue = (r_state == S_READ) && (w_occ < 3'd2);

    assign freq_oe     = w_issue;
    assign freq_addr_a = w_issue ? {r_rd_cnt, 1'b0} : 8'd0;
    assign freq_addr_b = w_issue ? {r_rd_cnt, 1'b1} : 8'd0;

    assign ram_clean   = r_clean;
    assign ram_stat_en = r_stat_en;
    assign stat_ready  = r_stat_ready;
    assign done        = r_done;
    assign ctrl_busy   = r_busy;

    assign sym_valid = (r_fifo_cnt != 2'd0);
    assign sym_idx   = sym_valid ? {r_fifo_idx[r_rd_ptr], 1'b0} : 8'd0;
    assign sym_freq0 = sym_valid ? r_fifo_f0[r_rd_ptr] : 20'd0;
    assign sym_freq1 = sym_valid ? r_fifo_f1[r_rd_ptr] : 20'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_clean      <= 1'b0;
            r_stat_en    <= 1'b0;
            r_stat_ready <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_busy_seen  <= 1'b0;
            r_guard      <= 1'b0;
            r_drain_cnt  <= 1'b0;
            r_rd_cnt     <= 7'd0;
        end else begin
            r_clean <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (blk_start) begin
                        r_state <= S_CLEAN;
                        r_clean <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLEAN: begin
                    r_state     <= S_CLR_WAIT;
                    r_busy_seen <= 1'b0;
                    r_guard     <= 1'b0;
                end
                // The guard cycle lets the RAM's last clearing write land after busy falls.
                S_CLR_WAIT: begin
                    if (r_guard) begin
                        r_state      <= S_STAT;
                        r_stat_en    <= 1'b1;
                        r_stat_ready <= 1'b1;
                    end else if (r_busy_seen && !ram_busy) begin
                        r_guard <= 1'b1;
                    end else if (ram_busy) begin
                        r_busy_seen <= 1'b1;
                    end
                end
                S_STAT: begin
                    if (blk_end) begin
                        r_state      <= S_DRAIN;
                        r_stat_ready <= 1'b0;
                        r_drain_cnt  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt) begin
                        r_state   <= S_READ;
                        r_stat_en <= 1'b0;
                        r_rd_cnt  <= 7'd0;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_rd_cnt <= r_rd_cnt + 7'd1;
                        if (r_rd_cnt == 7'd127) r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (r_fifo_cnt == 2'd0 && !r_vld_p1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: read in flight, RAM data returns this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            r_vld_p1   <= w_issue;
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Stage p2: merged beat enters the output FIFO.
    always_ff @(posedge clk) begin
        if (w_issue) r_idx_p1 <= r_rd_cnt;
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= r_idx_p1;
            r_fifo_f0[r_wr_ptr]  <= merge4(freq_value1a, freq_value2a, freq_value3a, freq_value4a);
            r_fifo_f1[r_wr_ptr]  <= merge4(freq_value1b, freq_value2b, freq_value3b, freq_value4b);
        end
    end

`ifdef FREQ_TOTAL_EN
    logic [27:0] r_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= 28'd0;
        end else if (r_state == S_IDLE && blk_start) begin
            r_total <= 28'd0;
        end else if (w_pop) begin
            r_total <= r_total + {8'd0, sym_freq0} + {8'd0, sym_freq1};
        end
    end

    assign total_freq = r_total;
`endif

endmodule

// File: tb/tb_freq_stat_ctrl.sv
// Directed bench for freq_stat_ctrl with a behavioural four-bank frequency RAM
// (2-cycle read-modify-write, busy-signalled clean, 1-cycle read latency).
module tb_freq_stat_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, blk_start, blk_end, sym_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_mask;
    logic        stat_ready, ram_clean, ram_busy, ram_stat_en, freq_oe, freq_valid;
    logic [7:0]  freq_addr_a, freq_addr_b, sym_idx;
    logic [19:0] sym_freq0, sym_freq1;
    logic        sym_valid, done, ctrl_busy;
    logic [17:0] rd_a [4];
    logic [17:0] rd_b [4];
`ifdef FREQ_TOTAL_EN
    logic [27:0] total_freq;
    logic [27:0] total_at_done;
`endif

    int checks = 0;
    int failures = 0;

    freq_stat_ctrl dut (
        .clk(clk), .rst(rst), .blk_start(blk_start), .blk_end(blk_end),
        .stat_ready(stat_ready), .ram_clean(ram_clean), .ram_busy(ram_busy),
        .ram_stat_en(ram_stat_en), .freq_oe(freq_oe),
        .freq_addr_a(freq_addr_a), .freq_addr_b(freq_addr_b),
        .freq_value1a(rd_a[0]), .freq_value2a(rd_a[1]), .freq_value3a(rd_a[2]), .freq_value4a(rd_a[3]),
        .freq_value1b(rd_b[0]), .freq_value2b(rd_b[1]), .freq_value3b(rd_b[2]), .freq_value4b(rd_b[3]),
        .freq_valid(freq_valid), .sym_idx(sym_idx), .sym_freq0(sym_freq0), .sym_freq1(sym_freq1),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .done(done), .ctrl_busy(ctrl_busy)
`ifdef FREQ_TOTAL_EN
      , .total_freq(total_freq)
`endif
    );

    // Behavioural RAM: lane j of each beat counts into bank j when j < in_mask.
    logic [17:0] bank [4][256];
    int          busy_cnt = 0;
    logic        p1_v = 1'b0, p2_v = 1'b0, rd_v = 1'b0;
    logic [31:0] p1_d, p2_d;
    logic [2:0]  p1_m, p2_m;

    always @(posedge clk) begin
        if (ram_clean) begin
            busy_cnt <= 4;
            for (int b = 0; b < 4; b++)
                for (int s = 0; s < 256; s++) bank[b][s] <= 18'd0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        p1_v <= in_valid && ram_stat_en;
        p1_d <= in_data;
        p1_m <= in_mask;
        p2_v <= p1_v;
        p2_d <= p1_d;
        p2_m <= p1_m;
        if (p2_v && ram_stat_en)
            for (int j = 0; j < 4; j++)
                if (j < int'(p2_m)) bank[j][p2_d[8*j +: 8]] <= bank[j][p2_d[8*j +: 8]] + 18'd1;
        rd_v <= freq_oe;
        if (freq_oe)
            for (int j = 0; j < 4; j++) begin
                rd_a[j] <= bank[j][freq_addr_a];
                rd_b[j] <= bank[j][freq_addr_b];
            end
    end
    assign ram_busy   = (busy_cnt != 0);
    assign freq_valid = rd_v;

    // Observation: accepted beats, done pulses, read issue timing, stall stability, issue gating.
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  q_idx [$];
    logic [19:0] q_f0 [$];
    logic [19:0] q_f1 [$];
    int done_cnt, clean_cnt, oe_cnt, first_oe, last_oe, be_cyc, last_acc, done_cyc;
    int occ = 0, gate_err, stall_err;
    logic        hold_pend = 1'b0;
    logic [7:0]  h_idx;
    logic [19:0] h_f0, h_f1;
    int exp_cnt [256];

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
            occ = 0;
        end else begin
            if (hold_pend && (sym_valid !== 1'b1 || sym_idx !== h_idx || sym_freq0 !== h_f0 || sym_freq1 !== h_f1))
                stall_err++;
            hold_pend = sym_valid && !sym_ready;
            h_idx = sym_idx;
            h_f0  = sym_freq0;
            h_f1  = sym_freq1;
            if (freq_oe) begin
                if (occ - int'(sym_valid && sym_ready) >= 2) gate_err++;
                oe_cnt++;
                if (first_oe < 0) first_oe = cyc;
                last_oe = cyc;
            end
            occ = occ + int'(freq_oe) - int'(sym_valid && sym_ready);
            if (sym_valid && sym_ready) begin
                q_idx.push_back(sym_idx);
                q_f0.push_back(sym_freq0);
                q_f1.push_back(sym_freq1);
                last_acc = cyc;
            end
            if (blk_end) be_cyc = cyc;
            if (ram_clean) clean_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef FREQ_TOTAL_EN
                total_at_done = total_freq;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_idx.delete();
        q_f0.delete();
        q_f1.delete();
        done_cnt = 0; clean_cnt = 0; oe_cnt = 0; first_oe = -1; last_oe = -1;
        be_cyc = -1; last_acc = -1; done_cyc = -1; gate_err = 0; stall_err = 0;
        for (int s = 0; s < 256; s++) exp_cnt[s] = 0;
    endtask

    task automatic wait_stat(output bit to);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (stat_ready) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] m, input bit last);
        in_valid = 1'b1; in_data = d; in_mask = m; blk_end = last;
        tick();
        in_valid = 1'b0; in_data = 32'd0; in_mask = 3'd0; blk_end = 1'b0;
    endtask

    task automatic readout(input bit rnd, input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            sym_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done_cnt != 0) begin
                to = 1'b0;
                break;
            end
        end
        sym_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({ram_clean, ram_stat_en, stat_ready, freq_oe, sym_valid, done, ctrl_busy} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {ram_clean, ram_stat_en, stat_ready, freq_oe, sym_valid, done, ctrl_busy});
        end
        checks++;
        if (freq_addr_a !== 8'd0 || freq_addr_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_addr got a=%0h b=%0h want 0/0", freq_addr_a, freq_addr_b);
        end
        checks++;
        if (sym_idx !== 8'd0 || sym_freq0 !== 20'd0 || sym_freq1 !== 20'd0) begin
            failures++;
            $display("FAIL reset_sym got idx=%0h f0=%0d f1=%0d want 0", sym_idx, sym_freq0, sym_freq1);
        end
`ifdef FREQ_TOTAL_EN
        checks++;
        if (total_freq !== 28'd0) begin
            failures++;
            $display("FAIL reset_total got=%0d want=0", total_freq);
        end
`endif
    endtask

    task automatic test_single_symbol();
        bit to;
        clear_mon();
        exp_cnt[8'h41] = 4000;
        blk_start = 1'b1;
        tick();
        checks++;
        if (ram_clean !== 1'b1 || ctrl_busy !== 1'b1) begin
            failures++;
            $display("FAIL clean_start got clean=%b busy=%b want 1/1", ram_clean, ctrl_busy);
        end
        blk_start = 1'b0;
        tick();
        checks++;
        if (ram_clean !== 1'b0) begin
            failures++;
            $display("FAIL clean_width got=%b want=0", ram_clean);
        end
        wait_stat(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL stat_wait got=timeout want=stat_ready");
        end
        for (int i = 0; i < 1000; i++) send(32'h41414141, 3'd4, i == 999);
        readout(1'b0, 1000, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL single_done got=timeout want=done");
        end
        checks++;
        if (q_idx.size() != 128) begin
            failures++;
            $display("FAIL single_beats got=%0d want=128", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 128; i++) begin
            checks++;
            if (q_idx[i] !== 8'(2*i) || q_f0[i] !== 20'(exp_cnt[2*i]) || q_f1[i] !== 20'(exp_cnt[2*i+1])) begin
                failures++;
                $display("FAIL single_beat%0d got idx=%0h f0=%0d f1=%0d want idx=%0h f0=%0d f1=%0d",
                         i, q_idx[i], q_f0[i], q_f1[i], 2*i, exp_cnt[2*i], exp_cnt[2*i+1]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL single_done_cnt got=%0d want=1", done_cnt);
        end
        checks++;
        if (oe_cnt != 128 || last_oe - first_oe + 1 != 128) begin
            failures++;
            $display("FAIL read_phase got oe=%0d span=%0d want 128/128", oe_cnt, last_oe - first_oe + 1);
        end
        checks++;
        if (first_oe - be_cyc < 2) begin
            failures++;
            $display("FAIL drain_gap got=%0d want>=2", first_oe - be_cyc);
        end
        checks++;
        if (done_cyc - last_acc < 1 || done_cyc - last_acc > 2) begin
            failures++;
            $display("FAIL done_lag got=%0d want 1..2", done_cyc - last_acc);
        end
        checks++;
        if (gate_err != 0 || clean_cnt != 1) begin
            failures++;
            $display("FAIL single_misc got gate_err=%0d cleans=%0d want 0/1", gate_err, clean_cnt);
        end
`ifdef FREQ_TOTAL_EN
        checks++;
        if (total_at_done !== 28'd4000) begin
            failures++;
            $display("FAIL single_total got=%0d want=4000", total_at_done);
        end
`endif
    endtask

    task automatic test_mixed_stall();
        bit to;
        clear_mon();
        exp_cnt[7] = 4;
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        wait_stat(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL mixed_stat_wait got=timeout want=stat_ready");
        end
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        send(32'h00000007, 3'd1, 1'b0);
        send(32'h07070707, 3'd3, 1'b1);
        blk_start = 1'b1;
        repeat (5) tick();
        blk_start = 1'b0;
        readout(1'b1, 3000, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL mixed_done got=timeout want=done");
        end
        checks++;
        if (q_idx.size() != 128) begin
            failures++;
            $display("FAIL mixed_beats got=%0d want=128", q_idx.size());
        end
        for (int i = 0; i < q_idx.size() && i < 128; i++) begin
            checks++;
            if (q_idx[i] !== 8'(2*i) || q_f0[i] !== 20'(exp_cnt[2*i]) || q_f1[i] !== 20'(exp_cnt[2*i+1])) begin
                failures++;
                $display("FAIL mixed_beat%0d got idx=%0h f0=%0d f1=%0d want idx=%0h f0=%0d f1=%0d",
                         i, q_idx[i], q_f0[i], q_f1[i], 2*i, exp_cnt[2*i], exp_cnt[2*i+1]);
            end
        end
        checks++;
        if (done_cnt != 1 || clean_cnt != 1) begin
            failures++;
            $display("FAIL mixed_ignore got done=%0d cleans=%0d want 1/1", done_cnt, clean_cnt);
        end
        checks++;
        if (stall_err != 0 || gate_err != 0) begin
            failures++;
            $display("FAIL mixed_stall got stall_err=%0d gate_err=%0d want 0/0", stall_err, gate_err);
        end
`ifdef FREQ_TOTAL_EN
        checks++;
        if (total_at_done !== 28'd4) begin
            failures++;
            $display("FAIL mixed_total got=%0d want=4", total_at_done);
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        bit to;
        clear_mon();
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        wait_stat(to);
        for (int i = 0; i < 5; i++) send(32'h00001010, 3'd2, i == 4);
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (q_idx.size() >= 40) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin
            failures++;
            $display("FAIL midrd_40beats got=%0d want>=40", q_idx.size());
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sym_valid !== 1'b0 || ctrl_busy !== 1'b0 || stat_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrd_reset got valid=%b busy=%b stat=%b want 0/0/0", sym_valid, ctrl_busy, stat_ready);
        end
        repeat (3) tick();
        checks++;
        if (sym_valid !== 1'b0 || freq_oe !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL midrd_idle got valid=%b oe=%b done=%0d want 0/0/0", sym_valid, freq_oe, done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_mon();
        blk_start = 1'b1;
        tick();
        blk_start = 1'b0;
        wait_stat(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL b2b_stat_wait got=timeout want=stat_ready");
        end
        send(32'h0, 3'd0, 1'b1);
        readout(1'b0, 1000, to);
        checks++;
        if (to || q_idx.size() != 128 || done_cnt != 1) begin
            failures++;
            $display("FAIL b2b_block got beats=%0d done=%0d timeout=%0d want 128/1/0", q_idx.size(), done_cnt, to);
        end
        for (int i = 0; i < q_idx.size() && i < 128; i++) begin
            checks++;
            if (q_idx[i] !== 8'(2*i) || q_f0[i] !== 20'd0 || q_f1[i] !== 20'd0) begin
                failures++;
                $display("FAIL b2b_beat%0d got idx=%0h f0=%0d f1=%0d want idx=%0h f0=0 f1=0",
                         i, q_idx[i], q_f0[i], q_f1[i], 2*i);
            end
        end
    endtask

    initial begin
        rst = 1'b1; blk_start = 1'b0; blk_end = 1'b0; sym_ready = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; in_mask = 3'd0;
        clear_mon();
        test_reset();
        test_single_symbol();
        test_mixed_stall();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
